// File: rtl/freecell_pkg.sv
// Shared card, location, opcode and error-code definitions for the FreeCell engine.
package freecell_pkg;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [1:0] {SUIT_H, SUIT_S, SUIT_C, SUIT_D} suit_e;

  typedef enum logic [3:0] {
    RANK_NONE = 4'd0, ACE = 4'd1, TWO, THREE, FOUR, FIVE, SIX, SEVEN,
    EIGHT, NINE, TEN, JACK, QUEEN, KING
  } rank_e;

  typedef enum logic [1:0] {CLS_TAB, CLS_FREE, CLS_HOME, CLS_RSV} loc_cls_e;

  typedef enum logic [1:0] {OP_LOAD, OP_MOVE, OP_CLEAR, OP_RSV} op_e;

  typedef enum logic [2:0] {
    ERR_OK, ERR_SRC_EMPTY, ERR_BAD_LOC, ERR_DST_OCC,
    ERR_RULE, ERR_COL_FULL, ERR_BAD_CARD, ERR_GAME_OVER
  } err_e;

  function automatic logic is_red(input logic [1:0] suit);
    return (suit == SUIT_H) || (suit == SUIT_D);
  endfunction

endpackage

// File: rtl/freecell_rule_check.sv
// Combinational legality check for one command against the fetched board snapshot.
module freecell_rule_check
  import freecell_pkg::*;
#(
  parameter int NUM_FREE  = 4,
  parameter int NUM_COLS  = 8,
  parameter int COL_DEPTH = 32,
  localparam int IDX_W    = $clog2(NUM_COLS),
  localparam int LOC_W    = 2 + IDX_W,
  localparam int HW       = $clog2(COL_DEPTH + 1)
) (
  input  logic [1:0]       op_i,
  input  logic [LOC_W-1:0] src_i,
  input  logic [LOC_W-1:0] dst_i,
  input  logic [3:0]       load_rank_i,
  input  card_t            src_card_i,
  input  card_t            dst_card_i,
  input  logic [HW-1:0]    dst_hgt_i,
  input  logic             win_i,
  output logic             legal_o,
  output logic [2:0]       err_o
);

  logic [1:0]       src_cls, dst_cls;
  logic [IDX_W-1:0] src_idx, dst_idx;
  logic             src_in, dst_in, bad_loc, rule_ok;

  function automatic logic in_range(input logic [1:0] cls, input logic [IDX_W-1:0] idx);
    case (cls)
      CLS_TAB:  return 32'(idx) < NUM_COLS;
      CLS_FREE: return 32'(idx) < NUM_FREE;
      CLS_HOME: return 32'(idx) < 4;
      default:  return 1'b0;
    endcase
  endfunction

  assign src_cls = src_i[LOC_W-1 -: 2];
  assign dst_cls = dst_i[LOC_W-1 -: 2];
  assign src_idx = src_i[IDX_W-1:0];
  assign dst_idx = dst_i[IDX_W-1:0];
  assign src_in  = in_range(src_cls, src_idx);
  assign dst_in  = in_range(dst_cls, dst_idx);

  always_comb begin
    bad_loc = 1'b0;
    case (op_i)
      OP_LOAD:  bad_loc = (dst_cls != CLS_TAB) || !dst_in;
      OP_MOVE:  bad_loc = (src_i == dst_i) || !((src_cls == CLS_TAB) || (src_cls == CLS_FREE)) ||
                          !src_in || !dst_in ||
                          ((dst_cls == CLS_HOME) && (dst_idx[1:0] != src_card_i.suit));
      OP_CLEAR: bad_loc = 1'b0;
      default:  bad_loc = 1'b1;
    endcase
  end

  // A home destination carries {suit, top rank} in dst_card_i.
  always_comb begin
    rule_ok = 1'b1;
    if (dst_cls == CLS_HOME)
      rule_ok = src_card_i.rank == dst_card_i.rank + 4'd1;
    else if ((dst_cls == CLS_TAB) && (dst_hgt_i != '0))
      rule_ok = (dst_card_i.rank == src_card_i.rank + 4'd1) &&
                (is_red(dst_card_i.suit) != is_red(src_card_i.suit));
  end

  always_comb begin
    err_o = ERR_OK;
    if (op_i != OP_CLEAR) begin
      if (win_i)
        err_o = ERR_GAME_OVER;
      else if (bad_loc)
        err_o = ERR_BAD_LOC;
      else if ((op_i == OP_LOAD) && ((load_rank_i == RANK_NONE) || (load_rank_i > KING)))
        err_o = ERR_BAD_CARD;
      else if ((op_i == OP_MOVE) && (src_card_i.rank == RANK_NONE))
        err_o = ERR_SRC_EMPTY;
      else if ((op_i == OP_MOVE) && (dst_cls == CLS_FREE) && (dst_card_i.rank != RANK_NONE))
        err_o = ERR_DST_OCC;
      else if ((dst_cls == CLS_TAB) && (32'(dst_hgt_i) == COL_DEPTH))
        err_o = ERR_COL_FULL;
      else if ((op_i == OP_MOVE) && !rule_ok)
        err_o = ERR_RULE;
    end
  end

  assign legal_o = (err_o == ERR_OK);

endmodule

// File: rtl/freecell_engine.sv
// FreeCell board state with a five-state accept/fetch/check/commit/respond sequencer.
module freecell_engine
  import freecell_pkg::*;
#(
  parameter int NUM_FREE  = 4,
  parameter int NUM_COLS  = 8,
  parameter int COL_DEPTH = 32,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(NUM_COLS),
  localparam int LOC_W    = 2 + IDX_W,
  localparam int HW       = $clog2(COL_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LOC_W-1:0] cmd_src,
  input  logic [LOC_W-1:0] cmd_dst,
  input  logic [5:0]       cmd_card,
  output logic             resp_valid,
  output logic             resp_legal,
  output logic [2:0]       resp_err,
  output logic [CNT_W-1:0] move_count,
  output logic             win
);

  localparam int NSLOT = 1 << IDX_W;
  localparam int DW    = $clog2(COL_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_COMMIT, S_RESP} state_e;

  state_e state_q, state_d;

  // Slot arrays are sized to the full index space so any encoded index reads safely.
  card_t            col_q [NSLOT][COL_DEPTH];
  logic [HW-1:0]    hgt_q [NSLOT];
  card_t            free_q [NSLOT];
  logic [3:0]       home_q [4];
  logic [CNT_W-1:0] move_cnt_q;
  logic             win_q, win_d;

  logic [1:0]       op_q;
  logic [LOC_W-1:0] src_q, dst_q;
  card_t            card_q;
  card_t            src_card_q, src_card_d, dst_card_q, dst_card_d;
  logic [HW-1:0]    dst_hgt_q, src_h, dst_h;
  logic [DW-1:0]    src_top, dst_top;
  logic             legal_q, legal_c;
  logic [2:0]       err_q, err_c;
  logic [3:0]       home_rank;

  logic [1:0]       src_cls, dst_cls;
  logic [IDX_W-1:0] src_idx, dst_idx;

  assign src_cls = src_q[LOC_W-1 -: 2];
  assign dst_cls = dst_q[LOC_W-1 -: 2];
  assign src_idx = src_q[IDX_W-1:0];
  assign dst_idx = dst_q[IDX_W-1:0];
  assign src_h   = hgt_q[src_idx];
  assign dst_h   = hgt_q[dst_idx];
  assign src_top = DW'(src_h - 1'b1);
  assign dst_top = DW'(dst_h - 1'b1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_legal = 1'b0;
    resp_err   = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_FETCH;
      end
      S_FETCH:  state_d = S_CHECK;
      S_CHECK:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        resp_legal = legal_q;
        resp_err   = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FETCH: snapshot source top, destination top (home yields {suit, top rank}) and height.
  always_comb begin
    src_card_d = '0;
    dst_card_d = '0;
    case (src_cls)
      CLS_TAB:  if (src_h != '0) src_card_d = col_q[src_idx][src_top];
      CLS_FREE: src_card_d = free_q[src_idx];
      default:  src_card_d = '0;
    endcase
    case (dst_cls)
      CLS_TAB:  if (dst_h != '0) dst_card_d = col_q[dst_idx][dst_top];
      CLS_FREE: dst_card_d = free_q[dst_idx];
      CLS_HOME: dst_card_d = {dst_idx[1:0], home_q[dst_idx[1:0]]};
      default:  dst_card_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if ((state_q == S_IDLE) && cmd_valid) begin
      op_q   <= cmd_op;
      src_q  <= cmd_src;
      dst_q  <= cmd_dst;
      card_q <= cmd_card;
    end
    if (state_q == S_FETCH) begin
      src_card_q <= src_card_d;
      dst_card_q <= dst_card_d;
      dst_hgt_q  <= (dst_cls == CLS_TAB) ? dst_h : '0;
    end
  end

  freecell_rule_check #(
    .NUM_FREE  (NUM_FREE),
    .NUM_COLS  (NUM_COLS),
    .COL_DEPTH (COL_DEPTH)
  ) u_rule (
    .op_i        (op_q),
    .src_i       (src_q),
    .dst_i       (dst_q),
    .load_rank_i (card_q.rank),
    .src_card_i  (src_card_q),
    .dst_card_i  (dst_card_q),
    .dst_hgt_i   (dst_hgt_q),
    .win_i       (win_q),
    .legal_o     (legal_c),
    .err_o       (err_c)
  );

  // CHECK: register verdict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      legal_q <= 1'b0;
      err_q   <= '0;
    end else if (state_q == S_CHECK) begin
      legal_q <= legal_c;
      err_q   <= err_c;
    end
  end

  // Win looks at home tops as they will stand after this commit.
  always_comb begin
    win_d     = 1'b1;
    home_rank = '0;
    for (int s = 0; s < 4; s++) begin
      home_rank = home_q[s];
      if (legal_q && (op_q == OP_MOVE) && (dst_cls == CLS_HOME) && (dst_idx[1:0] == 2'(s)))
        home_rank = src_card_q.rank;
      if (op_q == OP_CLEAR) home_rank = '0;
      if (home_rank != KING) win_d = 1'b0;
    end
  end

  // COMMIT: apply the command to board state only when legal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        hgt_q[i]  <= '0;
        free_q[i] <= '0;
      end
      for (int s = 0; s < 4; s++) home_q[s] <= '0;
      move_cnt_q <= '0;
      win_q      <= 1'b0;
    end else if (state_q == S_COMMIT) begin
      win_q <= win_d;
      if (op_q == OP_CLEAR) begin
        for (int i = 0; i < NSLOT; i++) begin
          hgt_q[i]  <= '0;
          free_q[i] <= '0;
        end
        for (int s = 0; s < 4; s++) home_q[s] <= '0;
        move_cnt_q <= '0;
      end else if (legal_q && (op_q == OP_LOAD)) begin
        hgt_q[dst_idx] <= dst_hgt_q + 1'b1;
      end else if (legal_q && (op_q == OP_MOVE)) begin
        if (src_cls == CLS_TAB) hgt_q[src_idx] <= src_h - 1'b1;
        else                    free_q[src_idx] <= '0;
        case (dst_cls)
          CLS_TAB:  hgt_q[dst_idx] <= dst_hgt_q + 1'b1;
          CLS_FREE: free_q[dst_idx] <= src_card_q;
          default:  home_q[dst_idx[1:0]] <= src_card_q.rank;
        endcase
        if (move_cnt_q != '1) move_cnt_q <= move_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if ((state_q == S_COMMIT) && legal_q && (op_q != OP_CLEAR) && (dst_cls == CLS_TAB))
      col_q[dst_idx][dst_hgt_q[DW-1:0]] <= (op_q == OP_LOAD) ? card_q : src_card_q;
  end

  assign move_count = move_cnt_q;
  assign win        = win_q;

endmodule

// File: tb/tb_freecell_engine.sv
// Directed scoreboard bench for freecell_engine with default parameters.
module tb_freecell_engine;

  localparam logic [1:0] LD = 2'd0, MV = 2'd1, CL = 2'd2, RS = 2'd3;
  localparam logic [2:0] E_OK = 3'd0, E_EMPTY = 3'd1, E_LOC = 3'd2, E_OCC = 3'd3,
                         E_RULE = 3'd4, E_FULL = 3'd5, E_CARD = 3'd6, E_GO = 3'd7;

  logic        clock, reset, cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_src, cmd_dst;
  logic [5:0]  cmd_card;
  logic        resp_valid, resp_legal, win;
  logic [2:0]  resp_err;
  logic [15:0] move_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  exp_q[$];
  logic        win_seen;
  logic [15:0] cnt_seen;

  freecell_engine dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_card   (cmd_card),
    .resp_valid (resp_valid),
    .resp_legal (resp_legal),
    .resp_err   (resp_err),
    .move_count (move_count),
    .win        (win)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [4:0] src,
                        input logic [4:0] dst, input logic [5:0] card,
                        input logic el, input logic [2:0] ee);
    int n;
    logic [3:0] e;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_card  = card;
    exp_q.push_back({el, ee});
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_op    = RS;
    cmd_card  = 6'h3f;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 3);
    if (resp_valid) begin
      e        = exp_q.pop_front();
      win_seen = win;
      cnt_seen = move_count;
      chk({tag, "_legal"}, 32'(resp_legal), 32'(e[3]));
      chk({tag, "_err"}, 32'(resp_err), 32'(e[2:0]));
    end
    @(posedge clock); #1;
    chk({tag, "_strobe"}, 32'(resp_valid), 0);
  endtask

  task automatic load(input string tag, input logic [4:0] dst, input logic [5:0] card,
                      input logic el, input logic [2:0] ee);
    do_cmd(tag, LD, 5'h00, dst, card, el, ee);
  endtask

  task automatic move(input string tag, input logic [4:0] src, input logic [4:0] dst,
                      input logic el, input logic [2:0] ee);
    do_cmd(tag, MV, src, dst, 6'h00, el, ee);
  endtask

  initial begin
    logic seen;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = LD;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_card  = '0;
    win_seen  = 1'b0;
    cnt_seen  = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_legal", 32'(resp_legal), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_count", 32'(move_count), 0);
    chk("rst_win", 32'(win), 0);

    // Basic tableau play and error codes.
    load("ld_h3", 5'h00, 6'h03, 1'b1, E_OK);
    load("ld_s2", 5'h01, 6'h12, 1'b1, E_OK);
    move("mv_s2_on_h3", 5'h01, 5'h00, 1'b1, E_OK);
    chk("count_1", 32'(cnt_seen), 1);
    chk("col0_hgt", 32'(dut.hgt_q[0]), 2);
    chk("col1_hgt", 32'(dut.hgt_q[1]), 0);
    move("mv_empty_src", 5'h01, 5'h02, 1'b0, E_EMPTY);
    move("mv_same_loc", 5'h00, 5'h00, 1'b0, E_LOC);
    load("ld_rank14", 5'h02, 6'h0E, 1'b0, E_CARD);
    load("ld_rank0", 5'h02, 6'h00, 1'b0, E_CARD);
    do_cmd("op_rsv", RS, 5'h00, 5'h01, 6'h01, 1'b0, E_LOC);
    move("free_idx_oob", 5'h00, 5'h0C, 1'b0, E_LOC);
    move("src_home", 5'h10, 5'h02, 1'b0, E_LOC);

    // Foundations.
    load("ld_ha", 5'h02, 6'h01, 1'b1, E_OK);
    move("mv_ha_home", 5'h02, 5'h10, 1'b1, E_OK);
    chk("home_h_top", 32'(dut.home_q[0]), 1);
    chk("count_2", 32'(cnt_seen), 2);
    move("s2_home_rule", 5'h00, 5'h11, 1'b0, E_RULE);
    move("s2_home_suit", 5'h00, 5'h10, 1'b0, E_LOC);

    // Free cells, colour rule, empty column.
    move("mv_to_free", 5'h00, 5'h08, 1'b1, E_OK);
    load("ld_c5", 5'h01, 6'h25, 1'b1, E_OK);
    move("free_occupied", 5'h01, 5'h08, 1'b0, E_OCC);
    load("ld_d2", 5'h02, 6'h32, 1'b1, E_OK);
    move("red_on_red", 5'h02, 5'h00, 1'b0, E_RULE);
    move("free_to_col", 5'h08, 5'h00, 1'b1, E_OK);
    move("rank_gap", 5'h02, 5'h01, 1'b0, E_RULE);
    move("to_empty_col", 5'h02, 5'h04, 1'b1, E_OK);
    chk("count_5", 32'(cnt_seen), 5);

    // Column capacity.
    for (int i = 0; i < 32; i++) load("fill", 5'h03, 6'h05, 1'b1, E_OK);
    load("col_full", 5'h03, 6'h05, 1'b0, E_FULL);
    chk("col3_hgt", 32'(dut.hgt_q[3]), 32);

    do_cmd("clear_1", CL, 5'h00, 5'h00, 6'h00, 1'b1, E_OK);
    chk("clear_count", 32'(move_count), 0);
    chk("clear_col3", 32'(dut.hgt_q[3]), 0);

    // Full game to win.
    for (int s = 0; s < 4; s++)
      for (int r = 13; r >= 1; r--)
        load("deal", 5'(s), {s[1:0], r[3:0]}, 1'b1, E_OK);
    for (int r = 1; r <= 13; r++)
      for (int s = 0; s < 4; s++) begin
        move("home", 5'(s), 5'(16 + s), 1'b1, E_OK);
        if (r == 13 && s == 2) chk("win_51", 32'(win_seen), 0);
      end
    chk("win_52", 32'(win_seen), 1);
    chk("count_52", 32'(cnt_seen), 52);
    move("game_over_mv", 5'h00, 5'h08, 1'b0, E_GO);
    load("game_over_ld", 5'h00, 6'h01, 1'b0, E_GO);
    chk("count_held", 32'(move_count), 52);
    do_cmd("clear_2", CL, 5'h00, 5'h00, 6'h00, 1'b1, E_OK);
    chk("clear_win", 32'(win_seen), 0);
    chk("clear_count2", 32'(cnt_seen), 0);

    // Reset while a legal MOVE is in CHECK.
    load("ab_h3", 5'h00, 6'h03, 1'b1, E_OK);
    load("ab_s2", 5'h01, 6'h12, 1'b1, E_OK);
    chk("ab_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = MV;
    cmd_src   = 5'h01;
    cmd_dst   = 5'h00;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("abort_no_resp", 32'(seen), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_count", 32'(move_count), 0);
    chk("abort_col0", 32'(dut.hgt_q[0]), 0);
    move("after_abort", 5'h01, 5'h00, 1'b0, E_EMPTY);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freecell_engine.md
# freecell_engine

Parametrised FreeCell game-state engine, the successor to the fixed 4-free-cell/8-column player. It holds tableau columns, free cells and home foundations in registers and accepts LOAD, MOVE and CLEAR commands over a valid/ready interface. Each command runs through a fixed multi-cycle validate/commit sequencer and returns one legality response; `win` rises when all four foundations reach king. It sits between the board controller (deal/move source) and the display/score logic.

## Interface
- `NUM_FREE`, default 4: free cells; range 1..`NUM_COLS`.
- `NUM_COLS`, default 8: tableau columns; range 4..16.
- `COL_DEPTH`, default 32: maximum cards per column; range 8..64.
- `CNT_W`, default 16: width of `move_count`.
- Derived: `IDX_W = $clog2(NUM_COLS)`, `LOC_W = 2 + IDX_W`, `HW = $clog2(COL_DEPTH+1)`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine idle and able to accept.
- `cmd_op`  in  2  0 LOAD, 1 MOVE, 2 CLEAR, 3 reserved (rejected as BAD_LOC).
- `cmd_src`  in  LOC_W  source location (MOVE); `{class[1:0], index}`, class 0 tableau, 1 free, 2 home.
- `cmd_dst`  in  LOC_W  destination location (MOVE), or target column (LOAD, class must be 0).
- `cmd_card`  in  6  `{suit[1:0], rank[3:0]}` for LOAD. Suit: 0 H, 1 S, 2 C, 3 D. Rank 1..13.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_legal`  out  1  command committed.
- `resp_err`  out  3  0 OK, 1 SRC_EMPTY, 2 BAD_LOC, 3 DST_OCCUPIED, 4 RULE, 5 COL_FULL, 6 BAD_CARD, 7 GAME_OVER.
- `move_count`  out  CNT_W  legal MOVEs since reset/CLEAR; saturates at all-ones.
- `win`  out  1  all foundations at rank 13.

## Operation
- State:
  - per column, `COL_DEPTH` × 6-bit card array plus `HW`-bit height;
  - `NUM_FREE` × 6-bit free cells (rank 0 = empty);
  - 4 × 4-bit home top rank, indexed by suit.
- FSM: IDLE → FETCH → CHECK → COMMIT → RESP → IDLE.
  - IDLE: `cmd_ready`=1; a handshake latches op/src/dst/card.
  - FETCH: register the source top card, destination top card and destination height.
  - CHECK: register legality and error code.
  - COMMIT: write state only if legal.
  - RESP: `resp_valid`=1, no backpressure.
- Error priority, first match wins:
  1. GAME_OVER: `win`=1 and op≠CLEAR.
  2. BAD_LOC: src==dst; src class home; class 3; index ≥ that class's count; home dst index ≠ card suit.
  3. BAD_CARD: LOAD rank 0 or >13.
  4. SRC_EMPTY.
  5. DST_OCCUPIED: free-cell destination non-empty.
  6. COL_FULL: destination height == `COL_DEPTH`.
  7. RULE: home requires rank == home top + 1; non-empty tableau destination requires dst rank == src rank + 1 and opposite colour (red = H, D).
- Empty tableau destination accepts any card. MOVE is single-card only.
- LOAD pushes `cmd_card` onto column `cmd_dst`; it is not counted. Duplicate cards are not checked.
- CLEAR empties everything, zeroes `move_count` and `win`, and is always legal.
- `win` is recomputed from home tops in COMMIT and is visible with `resp_valid`.

## Timing
- Handshake completes at edge N; `resp_valid` is high during the cycle following edge N+3; `cmd_ready` is high again the cycle after that. Throughput is 1 command per 5 cycles.
- `cmd_*` are ignored while `cmd_ready`=0.
- Reset values:
  - `cmd_ready`=1, `resp_valid`=0, `resp_legal`=0, `resp_err`=0, `move_count`=0, `win`=0;
  - all storage empty;
  - FSM in IDLE.
- Reset mid-command aborts it with no partial write and no response.
- Simultaneous count saturation and a legal move: the count holds and the move commits.

## Structure
- `freecell_pkg` holds:
  - `card_t` (6-bit);
  - suit/rank localparams (ACE=1 … KING=13);
  - location class codes;
  - op codes and error codes;
  - function `is_red(suit)`.
- Sub-module `freecell_rule_check`: combinational CHECK logic (inputs: op, classes, fetched cards, height, `win`; outputs: legal, err), instantiated once and registered by the engine.

## Test plan
- Reset, then LOAD col0 0x03 (H3) and col1 0x12 (S2); MOVE src 0x01 → dst 0x00 → legal, err 0; `move_count`=1; col0 height 2; col1 empty.
- MOVE from empty col1 (0x01 → 0x02) → err 1. MOVE 0x00 → 0x00 → err 2. LOAD card 0x0E → err 6.
- LOAD col2 0x01 (HA); MOVE 0x02 → 0x10 → legal, home H top = 1. MOVE S2 to 0x11 with spades home empty → err 4. MOVE S2 to 0x10 → err 2 (suit mismatch).
- Two MOVEs from different columns to free cell 0x08 → first legal, second err 3. Loading `COL_DEPTH`+1 cards into col3 → last returns err 5.
- Load 13 cards K…A into each of cols 0–3 (one suit each), then 52 MOVEs to home → `win`=1 with the 52nd `resp_valid`, `move_count`=52. Next MOVE → err 7. CLEAR → legal, `win`=0, count 0.
- Assert `reset` during CHECK of a legal MOVE → no state change, no `resp_valid`, `cmd_ready`=1 after release; the response arrives exactly 4 cycles after each accept throughout.
